uart_receiver: RTL and testbench

- Serial receive path of the UART; the counterpart of the transmit path.
- Oversamples srx_pad_i at 16x baud (enable tick) and recovers 5–8 data bits, optional parity and the first stop bit, all configured by lcr.
- Pushes each character, with per-character error flags, into an internal receive FIFO read by the register block.

---
 rtl/uart_receiver_pkg.sv | 45 ++++
 rtl/uart_rfifo.sv | 104 ++++++++++
 rtl/uart_receiver.sv | 178 +++++++++++++++++
 tb/tb_uart_receiver.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_receiver_pkg.sv
// Shared constants, state encoding and parity helper for the UART receive path.
package uart_receiver_pkg;

   localparam int UART_FIFO_REC_WIDTH = 11;
   localparam int UART_FIFO_DEPTH     = 16;
   localparam int UART_FIFO_POINTER_W = 4;
   localparam int UART_FIFO_COUNTER_W = 5;

   // Record layout: {data[7:0], break, parity_err, framing_err}
   localparam int UART_REC_FRAMING  = 0;
   localparam int UART_REC_PARITY   = 1;
   localparam int UART_REC_BREAK    = 2;
   localparam int UART_REC_DATA_LSB = 3;

   localparam int UART_LC_PE = 3;
   localparam int UART_LC_EP = 4;
   localparam int UART_LC_SP = 5;

   typedef enum logic [2:0] {
      sr_idle       = 3'd0,
      sr_rec_start  = 3'd1,
      sr_rec_bit    = 3'd2,
      sr_rec_parity = 3'd3,
      sr_rec_stop   = 3'd4,
      sr_push       = 3'd5,
      sr_wait_high  = 3'd6
   } rx_state_e;

   function automatic logic expected_parity(input logic [7:0] data, input logic ep, input logic sp);
      logic par;
      case ({ep, sp})
         2'b00:   par = ~^data;
         2'b01:   par = 1'b1;
         2'b10:   par = ^data;
         2'b11:   par = 1'b0;
         default: par = 1'b0;
      endcase
      return par;
   endfunction

   function automatic logic [2:0] char_last_bit(input logic [1:0] wls);
      return 3'd4 + {1'b0, wls};
   endfunction

endpackage

// File: rtl/uart_rfifo.sv
// 16-deep receive FIFO of 11-bit character records with overrun and error summary.
module uart_rfifo
   import uart_receiver_pkg::*;
(
   input  logic                           clk,
   input  logic                           wb_rst_i,
   input  logic                           push,
   input  logic                           pop,
   input  logic                           fifo_reset,
   input  logic                           reset_status,
   input  logic [UART_FIFO_REC_WIDTH-1:0] data_in,
   output logic [UART_FIFO_REC_WIDTH-1:0] data_out,
   output logic [UART_FIFO_COUNTER_W-1:0] count,
   output logic                           overrun,
   output logic                           error_bit
);

   logic [UART_FIFO_REC_WIDTH-1:0] mem_r [UART_FIFO_DEPTH];
   logic [UART_FIFO_POINTER_W-1:0] head_r;
   logic [UART_FIFO_POINTER_W-1:0] tail_r;
   logic [UART_FIFO_COUNTER_W-1:0] count_r;
   logic                           overrun_r;
   logic                           error_bit_r;
   logic                           full_s;
   logic                           empty_s;
   logic                           do_pop_s;
   logic                           do_push_s;
   logic                           err_any_s;
   logic [UART_FIFO_POINTER_W-1:0] offset_s;

   assign full_s    = (count_r == UART_FIFO_COUNTER_W'(UART_FIFO_DEPTH));
   assign empty_s   = (count_r == {UART_FIFO_COUNTER_W{1'b0}});
   assign do_pop_s  = pop && !empty_s;
   // A full FIFO still accepts a push when a pop frees a slot in the same clock.
   assign do_push_s = push && (!full_s || do_pop_s);

   // Storage, pointers, occupancy and the sticky overrun flag.
   always_ff @(posedge clk or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         for (int i = 0; i < UART_FIFO_DEPTH; i++) begin
            mem_r[i] <= {UART_FIFO_REC_WIDTH{1'b0}};
         end
         head_r    <= {UART_FIFO_POINTER_W{1'b0}};
         tail_r    <= {UART_FIFO_POINTER_W{1'b0}};
         count_r   <= {UART_FIFO_COUNTER_W{1'b0}};
         overrun_r <= 1'b0;
      end else begin
         if (fifo_reset) begin
            head_r  <= {UART_FIFO_POINTER_W{1'b0}};
            tail_r  <= {UART_FIFO_POINTER_W{1'b0}};
            count_r <= {UART_FIFO_COUNTER_W{1'b0}};
         end else begin
            if (do_push_s) begin
               mem_r[tail_r] <= data_in;
               tail_r        <= tail_r + UART_FIFO_POINTER_W'(1);
            end
            if (do_pop_s) begin
               head_r <= head_r + UART_FIFO_POINTER_W'(1);
            end
            case ({do_push_s, do_pop_s})
               2'b10:   count_r <= count_r + UART_FIFO_COUNTER_W'(1);
               2'b01:   count_r <= count_r - UART_FIFO_COUNTER_W'(1);
               default: count_r <= count_r;
            endcase
         end
         if (reset_status) begin
            overrun_r <= 1'b0;
         end else if (push && !do_push_s) begin
            overrun_r <= 1'b1;
         end
      end
   end

   // OR of the error flags of entries lying between head and head+count.
   always_comb begin
      err_any_s = 1'b0;
      offset_s  = {UART_FIFO_POINTER_W{1'b0}};
      for (int i = 0; i < UART_FIFO_DEPTH; i++) begin
         offset_s = UART_FIFO_POINTER_W'(i) - head_r;
         if (({1'b0, offset_s} < count_r) && (mem_r[i][UART_REC_BREAK:UART_REC_FRAMING] != 3'b000)) begin
            err_any_s = 1'b1;
         end else begin
            err_any_s = err_any_s;
         end
      end
   end

   // Registered error summary, cleared together with a flush.
   always_ff @(posedge clk or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         error_bit_r <= 1'b0;
      end else if (fifo_reset) begin
         error_bit_r <= 1'b0;
      end else begin
         error_bit_r <= err_any_s;
      end
   end

   assign data_out  = empty_s ? {UART_FIFO_REC_WIDTH{1'b0}} : mem_r[head_r];
   assign count     = count_r;
   assign overrun   = overrun_r;
   assign error_bit = error_bit_r;

endmodule

// File: rtl/uart_receiver.sv
// UART serial receiver: 16x oversampled frame recovery into the receive FIFO.
// Optional character timeout is built when UART_RX_TIMEOUT_EN is defined.
module uart_receiver
   import uart_receiver_pkg::*;
`ifdef UART_RX_TIMEOUT_EN
#(
   parameter int TOUT_TICKS = 640
)
`endif
(
   input  logic                           clk,
   input  logic                           wb_rst_i,
   input  logic [7:0]                     lcr,
   input  logic                           srx_pad_i,
   input  logic                           enable,
   input  logic                           rf_pop,
   input  logic                           rx_reset,
   input  logic                           lsr_mask,
   output logic [2:0]                     rstate,
   output logic [UART_FIFO_REC_WIDTH-1:0] rf_data_out,
   output logic [UART_FIFO_COUNTER_W-1:0] rf_count,
   output logic                           rf_overrun,
   output logic                           rf_error_bit,
   output logic                           rx_timeout
);

   logic                           srx_meta_r;
   logic                           srx_sync_r;
   rx_state_e                      state_r;
   logic [3:0]                     counter_r;
   logic [2:0]                     bit_cnt_r;
   logic [7:0]                     shift_r;
   logic                           parity_bit_r;
   logic                           parity_err_r;
   logic                           framing_err_r;
   logic                           break_r;
   logic                           rf_push_s;
   logic [UART_FIFO_REC_WIDTH-1:0] rec_s;
   logic                           lcr_unused_s;

   assign lcr_unused_s = ^{lcr[7:6], lcr[2]};

   // Two-flop synchronizer; idles high so reset does not look like a start bit.
   always_ff @(posedge clk or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         srx_meta_r <= 1'b1;
         srx_sync_r <= 1'b1;
      end else begin
         srx_meta_r <= srx_pad_i;
         srx_sync_r <= srx_meta_r;
      end
   end

   // Frame FSM: counter reaching zero marks the mid-bit sample point.
   always_ff @(posedge clk or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         state_r       <= sr_idle;
         counter_r     <= 4'd0;
         bit_cnt_r     <= 3'd0;
         shift_r       <= 8'd0;
         parity_bit_r  <= 1'b0;
         parity_err_r  <= 1'b0;
         framing_err_r <= 1'b0;
         break_r       <= 1'b0;
      end else if (state_r == sr_push) begin
         state_r <= framing_err_r ? sr_wait_high : sr_idle;
      end else if (enable) begin
         case (state_r)
            sr_idle: begin
               if (!srx_sync_r) begin
                  counter_r <= 4'd7;
                  state_r   <= sr_rec_start;
               end
            end
            sr_rec_start: begin
               if (counter_r != 4'd0) begin
                  counter_r <= counter_r - 4'd1;
               end else if (srx_sync_r) begin
                  state_r <= sr_idle;
               end else begin
                  counter_r     <= 4'd15;
                  bit_cnt_r     <= 3'd0;
                  shift_r       <= 8'd0;
                  parity_bit_r  <= 1'b0;
                  parity_err_r  <= 1'b0;
                  framing_err_r <= 1'b0;
                  break_r       <= 1'b0;
                  state_r       <= sr_rec_bit;
               end
            end
            sr_rec_bit: begin
               if (counter_r != 4'd0) begin
                  counter_r <= counter_r - 4'd1;
               end else begin
                  shift_r[bit_cnt_r] <= srx_sync_r;
                  counter_r          <= 4'd15;
                  bit_cnt_r          <= bit_cnt_r + 3'd1;
                  if (bit_cnt_r == char_last_bit(lcr[1:0])) begin
                     state_r <= lcr[UART_LC_PE] ? sr_rec_parity : sr_rec_stop;
                  end
               end
            end
            sr_rec_parity: begin
               if (counter_r != 4'd0) begin
                  counter_r <= counter_r - 4'd1;
               end else begin
                  parity_bit_r <= srx_sync_r;
                  parity_err_r <= (srx_sync_r != expected_parity(shift_r, lcr[UART_LC_EP], lcr[UART_LC_SP]));
                  counter_r    <= 4'd15;
                  state_r      <= sr_rec_stop;
               end
            end
            sr_rec_stop: begin
               if (counter_r != 4'd0) begin
                  counter_r <= counter_r - 4'd1;
               end else begin
                  framing_err_r <= !srx_sync_r;
                  break_r       <= (shift_r == 8'd0) && !(lcr[UART_LC_PE] && parity_bit_r) && !srx_sync_r;
                  state_r       <= sr_push;
               end
            end
            sr_wait_high: begin
               if (srx_sync_r) begin
                  state_r <= sr_idle;
               end
            end
            default: state_r <= sr_idle;
         endcase
      end
   end

   assign rf_push_s = (state_r == sr_push);
   assign rec_s     = {shift_r, break_r, parity_err_r, framing_err_r};
   assign rstate    = state_r;

   uart_rfifo u_rfifo (
      .clk          (clk),
      .wb_rst_i     (wb_rst_i),
      .push         (rf_push_s),
      .pop          (rf_pop),
      .fifo_reset   (rx_reset),
      .reset_status (lsr_mask),
      .data_in      (rec_s),
      .data_out     (rf_data_out),
      .count        (rf_count),
      .overrun      (rf_overrun),
      .error_bit    (rf_error_bit)
   );

`ifdef UART_RX_TIMEOUT_EN
   localparam int TW = $clog2(TOUT_TICKS);

   logic [TW-1:0] tout_cnt_r;
   logic          rx_timeout_r;

   // Idle-line timer: restarts on FIFO activity, fires after TOUT_TICKS quiet ticks.
   always_ff @(posedge clk or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         tout_cnt_r   <= {TW{1'b0}};
         rx_timeout_r <= 1'b0;
      end else if (rf_push_s || rf_pop || (rf_count == {UART_FIFO_COUNTER_W{1'b0}})) begin
         tout_cnt_r   <= TW'(TOUT_TICKS - 1);
         rx_timeout_r <= 1'b0;
      end else if (enable) begin
         if (tout_cnt_r == {TW{1'b0}}) begin
            rx_timeout_r <= 1'b1;
         end else begin
            tout_cnt_r <= tout_cnt_r - TW'(1);
         end
      end
   end

   assign rx_timeout = rx_timeout_r;
`else
   assign rx_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_uart_receiver.sv
// Self-checking bench for uart_receiver: directed vector table, random frames vs. model, corner sequences.
module tb_uart_receiver;
   import uart_receiver_pkg::*;

   logic        clk = 1'b0;
   logic        wb_rst_i;
   logic [7:0]  lcr;
   logic        srx_pad_i;
   logic        enable;
   logic        rf_pop;
   logic        rx_reset;
   logic        lsr_mask;
   logic [2:0]  rstate;
   logic [10:0] rf_data_out;
   logic [4:0]  rf_count;
   logic        rf_overrun;
   logic        rf_error_bit;
   logic        rx_timeout;

   int total = 0;
   int bad   = 0;
   int div   = 1;
   int ecnt  = 0;

`ifdef UART_RX_TIMEOUT_EN
   localparam bit TOUT_ON = 1'b1;
`else
   localparam bit TOUT_ON = 1'b0;
`endif

   typedef struct {
      logic [7:0]  lcr;
      logic [7:0]  data;
      logic        par;
      logic        stop;
      logic [10:0] exp;
   } vec_t;

   vec_t        vecs [9];
   logic [10:0] expq [$];

   uart_receiver dut (
      .clk          (clk),
      .wb_rst_i     (wb_rst_i),
      .lcr          (lcr),
      .srx_pad_i    (srx_pad_i),
      .enable       (enable),
      .rf_pop       (rf_pop),
      .rx_reset     (rx_reset),
      .lsr_mask     (lsr_mask),
      .rstate       (rstate),
      .rf_data_out  (rf_data_out),
      .rf_count     (rf_count),
      .rf_overrun   (rf_overrun),
      .rf_error_bit (rf_error_bit),
      .rx_timeout   (rx_timeout)
   );

   always #5 clk = ~clk;

   initial begin
      enable = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         enable = (ecnt == 0);
         ecnt   = (ecnt + 1) % div;
      end
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic pop_one();
      rf_pop = 1'b1;
      tick(1);
      rf_pop = 1'b0;
      tick(1);
   endtask

   task automatic send_frame(input logic [7:0] d, input logic par, input logic stop);
      int nbits;
      int bt;
      nbits = 5 + int'(lcr[1:0]);
      bt    = 16 * div;
      srx_pad_i = 1'b0;
      tick(bt);
      for (int i = 0; i < nbits; i++) begin
         srx_pad_i = d[i];
         tick(bt);
      end
      if (lcr[3]) begin
         srx_pad_i = par;
         tick(bt);
      end
      srx_pad_i = stop;
      tick(bt);
      srx_pad_i = 1'b1;
      tick(bt);
   endtask

   // Reference: a character as the receiver should report it, from line-level rules.
   function automatic logic [10:0] model(input logic [7:0] l, input logic [7:0] d, input logic par, input logic stop);
      int         nbits;
      int         ones;
      logic [7:0] data;
      logic       pe;
      logic       correct;
      logic       perr;
      logic       brk;
      nbits = 5 + int'(l[1:0]);
      data  = d & 8'((1 << nbits) - 1);
      ones  = $countones(data);
      pe    = l[3];
      if (l[5]) correct = ~l[4];
      else      correct = 1'((ones + (l[4] ? 0 : 1)) % 2);
      perr = pe && (par != correct);
      brk  = (data == 8'd0) && (!pe || !par) && !stop;
      return {data, brk, perr, !stop};
   endfunction

   initial begin
      vecs[0] = '{8'h03, 8'hA5, 1'b0, 1'b1, 11'h528};
      vecs[1] = '{8'h1B, 8'h01, 1'b0, 1'b1, 11'h00A};
      vecs[2] = '{8'h1B, 8'h01, 1'b1, 1'b1, 11'h008};
      vecs[3] = '{8'h0B, 8'h03, 1'b1, 1'b1, 11'h018};
      vecs[4] = '{8'h00, 8'h1F, 1'b0, 1'b1, 11'h0F8};
      vecs[5] = '{8'h01, 8'h2A, 1'b0, 1'b0, 11'h151};
      vecs[6] = '{8'h2B, 8'h80, 1'b0, 1'b1, 11'h402};
      vecs[7] = '{8'h3B, 8'h00, 1'b0, 1'b0, 11'h005};
      vecs[8] = '{8'h02, 8'h7F, 1'b0, 1'b1, 11'h3F8};

      wb_rst_i  = 1'b1;
      srx_pad_i = 1'b1;
      lcr       = 8'h03;
      rf_pop    = 1'b0;
      rx_reset  = 1'b0;
      lsr_mask  = 1'b0;
      tick(3);
      wb_rst_i = 1'b0;
      tick(2);

      check("reset_rstate",  32'(rstate), 32'd0);
      check("reset_count",   32'(rf_count), 32'd0);
      check("reset_data",    32'(rf_data_out), 32'd0);
      check("reset_overrun", 32'(rf_overrun), 32'd0);
      check("reset_errbit",  32'(rf_error_bit), 32'd0);
      check("reset_timeout", 32'(rx_timeout), 32'd0);

      // Directed vector table
      for (int v = 0; v < 9; v++) begin
         lcr = vecs[v].lcr;
         send_frame(vecs[v].data, vecs[v].par, vecs[v].stop);
         check($sformatf("vec%0d_count", v), 32'(rf_count), 32'd1);
         check($sformatf("vec%0d_data", v), 32'(rf_data_out), 32'(vecs[v].exp));
         check($sformatf("vec%0d_errbit", v), 32'(rf_error_bit), 32'(vecs[v].exp[2:0] != 3'b000));
         check($sformatf("vec%0d_rstate", v), 32'(rstate), 32'd0);
         pop_one();
         check($sformatf("vec%0d_popped", v), 32'(rf_count), 32'd0);
      end

      // Random frames at a slower tick rate, three per batch, against the model
      div = 2;
      for (int b = 0; b < 8; b++) begin
         logic any_err;
         any_err = 1'b0;
         for (int k = 0; k < 3; k++) begin
            logic [7:0] d;
            logic       par;
            logic       stop;
            lcr  = 8'($urandom_range(0, 63));
            d    = 8'($urandom);
            par  = 1'($urandom_range(0, 1));
            stop = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 5) == 0) begin
               d    = 8'h00;
               par  = 1'b0;
               stop = 1'b0;
            end
            expq.push_back(model(lcr, d, par, stop));
            send_frame(d, par, stop);
         end
         foreach (expq[i]) any_err = any_err | (expq[i][2:0] != 3'b000);
         check($sformatf("rnd%0d_count", b), 32'(rf_count), 32'd3);
         check($sformatf("rnd%0d_errbit", b), 32'(rf_error_bit), 32'(any_err));
         while (expq.size() > 0) begin
            check($sformatf("rnd%0d_data", b), 32'(rf_data_out), 32'(expq.pop_front()));
            pop_one();
         end
         check($sformatf("rnd%0d_empty", b), 32'(rf_count), 32'd0);
      end
      div = 1;
      tick(4);

      // Short low glitch is rejected as a false start
      srx_pad_i = 1'b0;
      tick(5);
      check("glitch_in_start", 32'(rstate), 32'd1);
      tick(3);
      srx_pad_i = 1'b1;
      tick(20);
      check("glitch_rstate", 32'(rstate), 32'd0);
      check("glitch_count",  32'(rf_count), 32'd0);

      // Line held low for three character times: one break record, then wait for high
      lcr = 8'h0B;
      srx_pad_i = 1'b0;
      tick(3 * 12 * 16);
      check("break_wait_high", 32'(rstate), 32'd6);
      check("break_count",     32'(rf_count), 32'd1);
      srx_pad_i = 1'b1;
      tick(8);
      check("break_idle",   32'(rstate), 32'd0);
      check("break_single", 32'(rf_count), 32'd1);
      check("break_data",   32'(rf_data_out), 32'h007);
      check("break_errbit", 32'(rf_error_bit), 32'd1);
      pop_one();

      // Pop on empty is ignored
      pop_one();
      check("pop_empty_count", 32'(rf_count), 32'd0);

      // Seventeen characters without popping: full plus overrun
      lcr = 8'h03;
      for (int k = 0; k < 17; k++) begin
         send_frame(8'(8'h10 + k), 1'b0, (k == 2) ? 1'b0 : 1'b1);
      end
      check("ovr_count",   32'(rf_count), 32'd16);
      check("ovr_flag",    32'(rf_overrun), 32'd1);
      check("ovr_head",    32'(rf_data_out), 32'h080);
      check("ovr_errbit",  32'(rf_error_bit), 32'd1);
      lsr_mask = 1'b1;
      tick(1);
      lsr_mask = 1'b0;
      tick(1);
      check("ovr_cleared", 32'(rf_overrun), 32'd0);
      check("ovr_kept",    32'(rf_count), 32'd16);
      rx_reset = 1'b1;
      tick(1);
      rx_reset = 1'b0;
      tick(2);
      check("flush_count",  32'(rf_count), 32'd0);
      check("flush_errbit", 32'(rf_error_bit), 32'd0);

      // Flush while a character is in flight: that character still lands
      send_frame(8'h33, 1'b0, 1'b1);
      fork
         send_frame(8'h5A, 1'b0, 1'b1);
         begin
            tick(60);
            rx_reset = 1'b1;
            tick(1);
            rx_reset = 1'b0;
         end
      join
      check("inflight_count", 32'(rf_count), 32'd1);
      check("inflight_data",  32'(rf_data_out), 32'h2D0);
      pop_one();

      // Character timeout (stays 0 when the feature is not built)
      send_frame(8'hA5, 1'b0, 1'b1);
      tick(590);
      check("tout_early", 32'(rx_timeout), 32'd0);
      tick(60);
      check("tout_fired", 32'(rx_timeout), 32'(TOUT_ON));
      pop_one();
      check("tout_cleared", 32'(rx_timeout), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
